router_nport: RTL and testbench
===============================

# router_nport

Parametrised single-input, N-output packet router: the successor to the 3-port, 8-bit router. It accepts header/payload/parity packets on one byte stream and steers each packet into a per-destination FIFO. It checks parity and payload length, drops packets addressed to non-existent ports, and flushes any output FIFO its consumer abandons. It sits between the packet source (pkt_valid/data_in/busy) and N independent readers (read_enb/vld_out/data_out).

## Interface
- DATA_W, 8: byte width; header = {length[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}
- ADDR_W, 2: address field width
- N_PORTS, 3: output ports, 1..2**ADDR_W
- FIFO_DEPTH, 16: entries per output FIFO, power of 2, ≥4
- TIMEOUT, 30: idle-consumer cycles before a FIFO is flushed, ≥1

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  high for header and payload bytes, low for the parity byte
- data_in  in  DATA_W  packet byte
- read_enb  in  N_PORTS  per-port read request
- data_out  out  N_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W], registered
- vld_out  out  N_PORTS  port i FIFO not empty
- busy  out  1  source must hold data_in/pkt_valid this cycle
- err  out  1  last completed packet had bad parity or length

## Operation
- Write FSM states: IDLE, LOAD, CHECK, DROP.
- IDLE: on pkt_valid=1 and busy=0, latch the header.
  - addr < N_PORTS: write the header to FIFO[addr], clear err, init parity = header, init count = 0, go to LOAD.
  - addr ≥ N_PORTS: go to DROP; header not stored; err unchanged.
- LOAD, pkt_valid=1, busy=0: write the byte to FIFO[dest], parity ^= byte, count++ (saturates at 2**(DATA_W-ADDR_W)).
- LOAD, pkt_valid=0, busy=0: parity byte. Write it to FIFO[dest], go to CHECK.
- CHECK: one cycle, busy=1.
  - err <= (parity ≠ parity byte) | (count ≠ header length).
  - Return to IDLE.
- DROP: bytes are consumed without storing, busy=0. The first cycle with pkt_valid=0 consumes the parity byte and returns to IDLE.
- busy is combinational:
  - IDLE: pkt_valid & addr<N_PORTS & full[addr]
  - LOAD: full[dest]
  - CHECK: 1
  - DROP: 0
  - A read of a full FIFO in the same cycle does not clear busy.
- Length-0 packet: header followed directly by parity; FIFO receives 2 bytes.
- Read side, port i: on a clock edge with read_enb[i]=1 and vld_out[i]=1, data_out[i] <= head and pop. Otherwise data_out[i] holds. read_enb with an empty FIFO is ignored.
- Timeout, port i:
  - A counter increments each cycle with vld_out[i]=1 and read_enb[i]=0.
  - It clears on any read or when the FIFO is empty.
  - On reaching TIMEOUT, FIFO i is flushed (pointers reset, vld_out[i]=0 next cycle) and the counter clears.
  - If a write to port i coincides with the flush, flush wins and the write is discarded. The FSM still advances and the source is not stalled.
- FIFO occupancy counter is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- err level holds until the next accepted valid header or reset.

## Timing
- Reset (async assert, sync to clock on deassert):
  - FSM to IDLE; all FIFOs empty; timeout counters 0.
  - data_out=0, vld_out=0, err=0, busy=0.
- Write latency: a byte accepted at edge N is in the FIFO after N. vld_out rises after the header edge.
- Read latency: read_enb sampled at edge M; data_out valid after M, one byte per cycle.
- err is valid the edge after CHECK, i.e. 2 edges after the parity byte is accepted.
- A new header may be presented in the cycle after CHECK. During CHECK, busy=1 blocks it.
- Full packet of L payload bytes into an empty FIFO with no stall: L+2 accept cycles plus 1 CHECK cycle.
- Reset asserted mid-packet: immediate return to reset state. The partial packet is lost and the source restarts with a header.

## Test plan
- Reset, then send addr 0, length 14, correct parity; read port 0 after 2 cycles → 16 bytes out in order (header 0x38 first), vld_out[0] falls after the last pop, err=0, busy never 1.
- Send addr 1, length 16 with inverted parity → err=1 two edges after the parity byte; err clears on the next valid header.
- With N_PORTS=3, send addr 3, length 17 → no vld_out rises, busy stays 0, err unchanged. A following addr-2 packet routes correctly.
- FIFO_DEPTH=16, addr 2, length 17, no reads → busy=1 once 16 bytes are stored. Holding read_enb[2] one cycle releases exactly one byte; all 19 bytes are delivered intact.
- Send addr 0, length 5 and never read → vld_out[0] drops exactly TIMEOUT=30 cycles after it rose; a later packet to port 0 is read normally.
- Send a header claiming length 10 but 9 payload bytes with correct XOR parity → err=1. Separately, assert resetn low mid-payload → all outputs 0 at once and the next packet routes cleanly.

Source files
------------

// File: rtl/router_nport_if.sv
// Packet-source and reader-side signal bundle for router_nport.
//   slave  : router side (consumes pkt_valid/data_in/read_enb, drives the rest)
//   master : source/reader side (drives pkt_valid/data_in/read_enb)
//   pkt_valid : high for header and payload bytes, low for the parity byte
//   data_in   : packet byte
//   busy      : source must hold data_in/pkt_valid this cycle
//   err       : last completed packet had bad parity or length
//   read_enb  : per-port read request
//   data_out  : port i at [i*DATA_W +: DATA_W], registered
//   vld_out   : port i FIFO not empty
interface router_nport_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_PORTS = 3
);
    logic                        pkt_valid;
    logic [DATA_W-1:0]           data_in;
    logic                        busy;
    logic                        err;
    logic [N_PORTS-1:0]          read_enb;
    logic [N_PORTS*DATA_W-1:0]   data_out;
    logic [N_PORTS-1:0]          vld_out;

    modport slave (
        input  pkt_valid, data_in, read_enb,
        output busy, err, data_out, vld_out
    );

    modport master (
        output pkt_valid, data_in, read_enb,
        input  busy, err, data_out, vld_out
    );
endinterface

// File: rtl/router_nport.sv
// Single-input, N-output packet router. Header/payload/parity packets arrive
// on one byte stream and are steered into a per-destination FIFO; parity and
// payload length are checked, packets to non-existent ports are dropped, and
// a FIFO whose consumer stays idle for TIMEOUT cycles is flushed.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : router_nport_if slave modport (source stream + N reader ports)
module router_nport #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned N_PORTS    = 3,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic           clock,
    input  logic           resetn,
    router_nport_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LEN_W = DATA_W - ADDR_W;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  parity_q, parity_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W:0]     cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  mem_q    [N_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_d    [N_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [N_PORTS];
    logic [PTR_W-1:0]   wr_ptr_d [N_PORTS];
    logic [PTR_W-1:0]   rd_ptr_q [N_PORTS];
    logic [PTR_W-1:0]   rd_ptr_d [N_PORTS];
    logic [CNT_W-1:0]   occ_q    [N_PORTS];
    logic [CNT_W-1:0]   occ_d    [N_PORTS];
    logic [TO_W-1:0]    to_q     [N_PORTS];
    logic [TO_W-1:0]    to_d     [N_PORTS];
    logic [DATA_W-1:0]  dout_q   [N_PORTS];
    logic [DATA_W-1:0]  dout_d   [N_PORTS];

    logic [N_PORTS-1:0]    full, vld, push, pop, flush;
    // Padded to the full address space so an out-of-range header address
    // can be used as an index without a range hazard.
    logic [2**ADDR_W-1:0]  full_pad;
    logic [ADDR_W-1:0]     hdr_addr;
    logic [LEN_W-1:0]      hdr_len;
    logic                  addr_ok;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_port;

    assign hdr_addr = bus.data_in[ADDR_W-1:0];
    assign hdr_len  = bus.data_in[DATA_W-1:ADDR_W];
    assign addr_ok  = 32'(hdr_addr) < N_PORTS;

    always_comb begin
        full_pad = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            full[i]     = occ_q[i] == CNT_W'(FIFO_DEPTH);
            vld[i]      = occ_q[i] != '0;
            full_pad[i] = full[i];
        end
    end

    // Write-side FSM: busy and the FIFO write strobe fall out of the state.
    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        parity_d = parity_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        wr_port  = dest_q;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy    = bus.pkt_valid & addr_ok & full_pad[hdr_addr];
                wr_port = hdr_addr;
                if (bus.pkt_valid && !busy) begin
                    if (addr_ok) begin
                        wr_en    = 1'b1;
                        dest_d   = hdr_addr;
                        err_d    = 1'b0;
                        parity_d = bus.data_in;
                        cnt_d    = '0;
                        len_d    = hdr_len;
                        state_d  = LOAD;
                    end else begin
                        state_d  = DROP;
                    end
                end
            end
            LOAD: begin
                busy = full_pad[dest_q];
                if (!busy) begin
                    wr_en = 1'b1;
                    if (bus.pkt_valid) begin
                        parity_d = parity_q ^ bus.data_in;
                        cnt_d    = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + (LEN_W+1)'(1);
                    end else begin
                        // Verdict is computed now but only published from CHECK.
                        bad_d   = (parity_q != bus.data_in) | (cnt_q != {1'b0, len_q});
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                busy    = 1'b1;
                err_d   = bad_q;
                state_d = IDLE;
            end
            DROP: begin
                if (!bus.pkt_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-port FIFO, read register and idle-consumer timeout.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        to_d     = to_q;
        dout_d   = dout_q;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            pop[i]   = bus.read_enb[i] & vld[i];
            // Fires on the edge the idle count would reach TIMEOUT.
            flush[i] = vld[i] & ~bus.read_enb[i] & (to_q[i] == TO_W'(TIMEOUT - 1));
            push[i]  = wr_en & (32'(wr_port) == i) & ~flush[i];
            if (flush[i]) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                occ_d[i]    = '0;
                to_d[i]     = '0;
            end else begin
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = bus.data_in;
                    wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    dout_d[i]   = mem_q[i][rd_ptr_q[i]];
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                end
                occ_d[i] = occ_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                to_d[i]  = (vld[i] && !bus.read_enb[i]) ? to_q[i] + TO_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            dest_q   <= '0;
            parity_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            occ_q    <= '{default: '0};
            to_q     <= '{default: '0};
            dout_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            parity_q <= parity_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            to_q     <= to_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array carries no reset; occupancy gates every read of it.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            bus.data_out[i*DATA_W +: DATA_W] = dout_q[i];
        end
    end

    assign bus.vld_out = vld;
    assign bus.busy    = busy;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_router_nport.sv
module tb_router_nport;
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    router_nport_if #(.DATA_W(8), .N_PORTS(3)) bus ();

    router_nport #(
        .DATA_W(8), .ADDR_W(2), .N_PORTS(3), .FIFO_DEPTH(16), .TIMEOUT(30)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepted = 0;
    int pkt_stalls = 0;
    int rd_mode = 0;          // 0: man_rd, 1: random, 2: always read
    logic [2:0] man_rd = '0;
    bit chk_vld = 1'b0;
    logic exp_err = 1'b0;
    logic [7:0] exp_q [3][$];  // reference model: bytes held per output port

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        case (rd_mode)
            0:       bus.read_enb = man_rd;
            1:       bus.read_enb = 3'($urandom);
            default: bus.read_enb = '1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Present one byte and hold it until the router accepts it.
    task automatic send_byte(input bit v, input logic [7:0] d, input int port);
        int n;
        @(negedge clock);
        bus.pkt_valid = v;
        bus.data_in   = d;
        #1;
        n = 0;
        while (bus.busy && n < 2000) begin
            pkt_stalls++;
            @(negedge clock); #1;
            n++;
        end
        if (bus.busy) fail("busy_stuck");
        @(posedge clock); #1;
        accepted++;
        if (port >= 0) exp_q[port].push_back(d);
    endtask

    task automatic send_pkt(input int addr, input int len_f, input int n_pay, input bit corrupt);
        logic [7:0] hdr, par, b;
        bit ok_dst;
        int port;
        ok_dst = addr < 3;
        port   = ok_dst ? addr : -1;
        hdr    = 8'((len_f << 2) | addr);
        par    = hdr;
        pkt_stalls = 0;
        send_byte(1'b1, hdr, port);
        if (ok_dst) begin
            exp_err = 1'b0;
            chk("err_clear_on_hdr", 32'(bus.err), 32'(exp_err));
        end
        for (int k = 0; k < n_pay; k++) begin
            b   = 8'($urandom);
            par = par ^ b;
            send_byte(1'b1, b, port);
        end
        if (corrupt) par = ~par;
        send_byte(1'b0, par, port);
        @(negedge clock); #1;
        chk("busy_after_parity", 32'(bus.busy), ok_dst ? 32'd1 : 32'd0);
        if (ok_dst) exp_err = corrupt || (n_pay != len_f);
        @(posedge clock); #1;
        chk("err_after_pkt", 32'(bus.err), 32'(exp_err));
    endtask

    task automatic drain();
        int n;
        rd_mode = 2;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_left", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
        @(negedge clock);
    endtask

    // Monitor: pops the scoreboard on every read the DUT performs.
    initial begin : monitor
        logic [2:0] fire;
        logic [7:0] e;
        forever begin
            @(negedge clock); #2;
            fire = bus.read_enb & bus.vld_out;
            if (chk_vld && resetn === 1'b1) begin
                for (int i = 0; i < 3; i++)
                    chk($sformatf("vld_out%0d", i), 32'(bus.vld_out[i]), 32'(exp_q[i].size() != 0));
            end
            @(posedge clock); #1;
            for (int i = 0; i < 3; i++) begin
                if (fire[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        fail($sformatf("unexpected_read%0d", i));
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("data_out%0d", i), 32'(bus.data_out[i*8 +: 8]), 32'(e));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int a, n, lf, t_r, t_f, acc0;
        bit c;
        resetn = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.data_in = '0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_vld_out", 32'(bus.vld_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        chk_vld = 1'b1;

        // Port 0, length 14, header 0x38, read continuously.
        rd_mode = 2;
        send_pkt(0, 14, 14, 1'b0);
        chk("t1_no_stall", 32'(pkt_stalls), 32'd0);
        drain();

        // Inverted parity sets err; next valid header clears it.
        send_pkt(1, 16, 16, 1'b1);
        drain();

        // Non-existent port: dropped, no stall, err held.
        send_pkt(3, 17, 17, 1'b0);
        chk("drop_no_stall", 32'(pkt_stalls), 32'd0);
        send_pkt(2, 4, 4, 1'b0);
        drain();

        // Randomised traffic.
        rd_mode = 1;
        for (int p = 0; p < 40; p++) begin
            a  = $urandom_range(0, 3);
            n  = $urandom_range(0, 20);
            lf = ($urandom_range(0, 7) == 0) ? ((n + 1) % 64) : n;
            c  = ($urandom_range(0, 5) == 0);
            send_pkt(a, lf, n, c);
        end
        drain();

        // Back-pressure: FIFO 2 fills at 16 bytes, one read frees one slot.
        rd_mode = 0;
        man_rd = '0;
        acc0 = accepted;
        fork
            send_pkt(2, 17, 17, 1'b0);
            begin
                int k;
                k = 0;
                while (!bus.busy && k < 200) begin
                    @(negedge clock); #1;
                    k++;
                end
                chk("stall_at_16", 32'(accepted - acc0), 32'd16);
                chk("stall_busy", 32'(bus.busy), 32'd1);
                man_rd = 3'b100;
                @(negedge clock); #1;
                man_rd = '0;
                @(negedge clock); #1;
                chk("stall_released", 32'(bus.busy), 32'd0);
                @(negedge clock); #1;
                chk("stall_one_more", 32'(accepted - acc0), 32'd17);
                chk("stall_full_again", 32'(bus.busy), 32'd1);
                rd_mode = 2;
            end
        join
        drain();

        // Abandoned FIFO is flushed exactly TIMEOUT cycles after vld rises.
        rd_mode = 0;
        chk_vld = 1'b0;
        fork
            send_pkt(0, 5, 5, 1'b0);
            begin
                int k;
                k = 0;
                while (!bus.vld_out[0] && k < 200) begin
                    @(negedge clock); #3;
                    k++;
                end
                t_r = cyc;
                k = 0;
                while (bus.vld_out[0] && k < 200) begin
                    @(negedge clock); #3;
                    k++;
                end
                t_f = cyc;
                chk("timeout_cycles", 32'(t_f - t_r), 32'd30);
            end
        join
        exp_q[0].delete();
        chk("vld0_after_flush", 32'(bus.vld_out[0]), 32'd0);
        chk_vld = 1'b1;
        rd_mode = 2;
        send_pkt(0, 3, 3, 1'b0);
        drain();

        // Short payload versus header length.
        send_pkt(1, 10, 9, 1'b0);
        drain();

        // Reset mid-payload.
        rd_mode = 0;
        send_byte(1'b1, 8'((6 << 2) | 1), 1);
        for (int k = 0; k < 3; k++) send_byte(1'b1, 8'($urandom), 1);
        chk_vld = 1'b0;
        @(negedge clock);
        resetn = 1'b0;
        bus.pkt_valid = 1'b0;
        #1;
        chk("midrst_vld_out", 32'(bus.vld_out), 32'd0);
        chk("midrst_data_out", 32'(bus.data_out), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        exp_err = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk_vld = 1'b1;
        rd_mode = 2;
        send_pkt(1, 4, 4, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
